// File: rtl/wb_pkg.sv
// Shared Wishbone bus widths and the SRAM slave FSM encoding.
// Imported by wb_sram_slave and wb_sram_mem.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 32;
    localparam int WB_SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_sram_mem.sv
// Single-port synchronous SRAM with per-byte write enables
// and a one-cycle registered read.
module wb_sram_mem
    import wb_pkg::*;
#(
    parameter int DEPTH_W = 12
) (
    input  logic                 clk,
    input  logic                 en_i,
    input  logic                 we_i,
    input  logic [WB_SEL_W-1:0]  sel_i,
    input  logic [DEPTH_W-1:0]   adr_i,
    input  logic [WB_DATA_W-1:0] dat_i,
    output logic [WB_DATA_W-1:0] dat_o
);

    logic [WB_DATA_W-1:0] mem_q [2**DEPTH_W];
    logic [WB_DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < WB_SEL_W; b++) begin
                    if (sel_i[b]) begin
                        mem_q[adr_i][8*b +: 8] <= dat_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[adr_i];
            end
        end
    end

    assign dat_o = rdata_q;

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone B3 classic SRAM slave with programmable wait states.
// Optional out-of-range error ack: define WB_SRAM_ERR_EN.
module wb_sram_slave
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WB_ADDR_W-1:0] wb_adr_i,
    input  logic [WB_DATA_W-1:0] wb_dat_i,
    output logic [WB_DATA_W-1:0] wb_dat_o,
    input  logic                 wb_we_i,
    input  logic [WB_SEL_W-1:0]  wb_sel_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_cyc_i,
`ifdef WB_SRAM_ERR_EN
    output logic                 wb_err_o,
`endif
    output logic                 wb_ack_o
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    wb_state_e              state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  adr_q, adr_d;
    logic                   we_q, we_d;
    logic [WB_SEL_W-1:0]    sel_q, sel_d;
    logic [WB_DATA_W-1:0]   dat_q, dat_d;
    logic                   bad_q, bad_d;
    logic                   req, bad_in, mem_go, mem_en;
    logic [WB_DATA_W-1:0]   rdata;
    logic                   adr_unused;

    assign req = wb_cyc_i & wb_stb_i;

`ifdef WB_SRAM_ERR_EN
    assign bad_in     = |wb_adr_i[WB_ADDR_W-1:ADDR_WIDTH+2];
    assign adr_unused = ^wb_adr_i[1:0];
`else
    assign bad_in     = 1'b0;
    assign adr_unused = ^{wb_adr_i[WB_ADDR_W-1:ADDR_WIDTH+2],
                          wb_adr_i[1:0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        bad_d   = bad_q;
        mem_go  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    adr_d = wb_adr_i[ADDR_WIDTH+1:2];
                    we_d  = wb_we_i;
                    sel_d = wb_sel_i;
                    dat_d = wb_dat_i;
                    bad_d = bad_in;
                    cnt_d = WS;
                    if (WS == 4'd0) begin
                        state_d = ACK;
                        mem_go  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = ACK;
                    cnt_d   = 4'd0;
                    mem_go  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // The access fires on the edge entering ACK, so reset on that edge kills it
    assign mem_en = mem_go & ~bad_d & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            bad_q   <= bad_d;
        end
    end

    wb_sram_mem #(
        .DEPTH_W (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .en_i  (mem_en),
        .we_i  (we_d),
        .sel_i (sel_d),
        .adr_i (adr_d),
        .dat_i (dat_d),
        .dat_o (rdata)
    );

    assign wb_ack_o = (state_q == ACK) & ~bad_q;
    assign wb_dat_o = (wb_ack_o & ~we_q) ? rdata : '0;

`ifdef WB_SRAM_ERR_EN
    assign wb_err_o = (state_q == ACK) & bad_q;
`endif

endmodule
